// File: rtl/muldiv_pkg.sv
// Shared ALU control codes and the state/mode encodings for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

    localparam int OP_W = 5;

    localparam logic [OP_W-1:0] OPAND   = 5'd0;
    localparam logic [OP_W-1:0] OPOR    = 5'd1;
    localparam logic [OP_W-1:0] OPXOR   = 5'd2;
    localparam logic [OP_W-1:0] OPNOR   = 5'd3;
    localparam logic [OP_W-1:0] OPADD   = 5'd4;
    localparam logic [OP_W-1:0] OPADDU  = 5'd5;
    localparam logic [OP_W-1:0] OPSUB   = 5'd6;
    localparam logic [OP_W-1:0] OPSUBU  = 5'd7;
    localparam logic [OP_W-1:0] OPSLT   = 5'd8;
    localparam logic [OP_W-1:0] OPSLTU  = 5'd9;
    localparam logic [OP_W-1:0] OPSLL   = 5'd10;
    localparam logic [OP_W-1:0] OPSRL   = 5'd11;
    localparam logic [OP_W-1:0] OPSRA   = 5'd12;
    localparam logic [OP_W-1:0] OPLUI   = 5'd13;
    localparam logic [OP_W-1:0] OPMULT  = 5'd14;
    localparam logic [OP_W-1:0] OPMULTU = 5'd15;
    localparam logic [OP_W-1:0] OPDIV   = 5'd16;
    localparam logic [OP_W-1:0] OPDIVU  = 5'd17;
    localparam logic [OP_W-1:0] OPMADD  = 5'd18;
    localparam logic [OP_W-1:0] OPMADDU = 5'd19;
    localparam logic [OP_W-1:0] OPMSUB  = 5'd20;
    localparam logic [OP_W-1:0] OPMSUBU = 5'd21;
    localparam logic [OP_W-1:0] OPMTHI  = 5'd22;
    localparam logic [OP_W-1:0] OPMTLO  = 5'd23;
    localparam logic [OP_W-1:0] OPMFHI  = 5'd24;
    localparam logic [OP_W-1:0] OPMFLO  = 5'd25;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FINISH
    } state_t;

    // How the finished result is folded into {HI,LO}.
    typedef enum logic [1:0] {
        M_SET,
        M_ADD,
        M_SUB,
        M_DIV
    } mode_t;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  div,
    input  logic [DATA_WIDTH-1:0] hi,
    input  logic [DATA_WIDTH-1:0] lo,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] hi_next,
    output logic [DATA_WIDTH-1:0] lo_next
);

    logic [DATA_WIDTH:0] sum;
    logic [DATA_WIDTH:0] shifted;
    logic [DATA_WIDTH:0] diff;

    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
        shifted = {hi, lo[DATA_WIDTH-1]};
        diff    = shifted - {1'b0, b};
        if (div) begin
            // Remainder stays below the divisor, so diff's top bit is a true borrow.
            if (!diff[DATA_WIDTH]) begin
                hi_next = diff[DATA_WIDTH-1:0];
                lo_next = {lo[DATA_WIDTH-2:0], 1'b1};
            end else begin
                hi_next = shifted[DATA_WIDTH-1:0];
                lo_next = {lo[DATA_WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_next = sum[DATA_WIDTH:1];
            lo_next = {sum[0], lo[DATA_WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide/accumulate unit owning HI/LO, with busy/done handshake for pipeline stalls.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 5
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic                  iStart,
    input  logic [OP_WIDTH-1:0]   iOp,
    input  logic [DATA_WIDTH-1:0] iA,
    input  logic [DATA_WIDTH-1:0] iB,
    input  logic                  iFlush,
    output logic                  oBusy,
    output logic                  oDone,
    output logic                  oDivByZero,
    output logic [DATA_WIDTH-1:0] oHI,
    output logic [DATA_WIDTH-1:0] oLO
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_WIDTH - 1);

    state_t                  state;
    mode_t                   mode;
    logic [CNT_W-1:0]        cnt;
    logic [DATA_WIDTH-1:0]   work_hi, work_lo, opnd;
    logic                    neg_q, neg_r, div_zero;

    logic                    dec_mul, dec_div, dec_sgn, dec_mthi, dec_mtlo;
    mode_t                   dec_mode;
    logic                    a_neg, b_neg;
    logic [DATA_WIDTH-1:0]   a_mag, b_mag;
    logic [DATA_WIDTH-1:0]   step_hi, step_lo;
    logic [2*DATA_WIDTH-1:0] prod, acc_next;
    logic [DATA_WIDTH-1:0]   quo, rem;

    always_comb begin
        dec_mul  = 1'b0;
        dec_div  = 1'b0;
        dec_sgn  = 1'b0;
        dec_mthi = 1'b0;
        dec_mtlo = 1'b0;
        dec_mode = M_SET;
        case (iOp)
            OP_WIDTH'(OPMULT):  begin dec_mul = 1'b1; dec_sgn = 1'b1; end
            OP_WIDTH'(OPMULTU): dec_mul = 1'b1;
            OP_WIDTH'(OPMADD):  begin dec_mul = 1'b1; dec_sgn = 1'b1; dec_mode = M_ADD; end
            OP_WIDTH'(OPMADDU): begin dec_mul = 1'b1; dec_mode = M_ADD; end
            OP_WIDTH'(OPMSUB):  begin dec_mul = 1'b1; dec_sgn = 1'b1; dec_mode = M_SUB; end
            OP_WIDTH'(OPMSUBU): begin dec_mul = 1'b1; dec_mode = M_SUB; end
            OP_WIDTH'(OPDIV):   begin dec_div = 1'b1; dec_sgn = 1'b1; dec_mode = M_DIV; end
            OP_WIDTH'(OPDIVU):  begin dec_div = 1'b1; dec_mode = M_DIV; end
            OP_WIDTH'(OPMTHI):  dec_mthi = 1'b1;
            OP_WIDTH'(OPMTLO):  dec_mtlo = 1'b1;
            default:            ;
        endcase
    end

    assign a_neg = dec_sgn & iA[DATA_WIDTH-1];
    assign b_neg = dec_sgn & iB[DATA_WIDTH-1];
    assign a_mag = a_neg ? -iA : iA;
    assign b_mag = b_neg ? -iB : iB;

    muldiv_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .div     (state == S_DIV),
        .hi      (work_hi),
        .lo      (work_lo),
        .b       (opnd),
        .hi_next (step_hi),
        .lo_next (step_lo)
    );

    always_comb begin
        prod = {work_hi, work_lo};
        if (neg_q) prod = -prod;
        case (mode)
            M_ADD:   acc_next = {oHI, oLO} + prod;
            M_SUB:   acc_next = {oHI, oLO} - prod;
            default: acc_next = prod;
        endcase
        quo = neg_q ? -work_lo : work_lo;
        rem = neg_r ? -work_hi : work_hi;
    end

    // NOTE: every register, including the iteration datapath, is cleared by reset so a
    // mid-operation reset leaves no partial product behind.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state      <= S_IDLE;
            mode       <= M_SET;
            cnt        <= '0;
            work_hi    <= '0;
            work_lo    <= '0;
            opnd       <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            div_zero   <= 1'b0;
            oBusy      <= 1'b0;
            oDone      <= 1'b0;
            oDivByZero <= 1'b0;
            oHI        <= '0;
            oLO        <= '0;
        end else if (iFlush) begin
            state      <= S_IDLE;
            cnt        <= '0;
            oBusy      <= 1'b0;
            oDone      <= 1'b0;
            oDivByZero <= 1'b0;
        end else begin
            oDone      <= 1'b0;
            oDivByZero <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (iStart) begin
                        if (dec_mthi) begin
                            oHI   <= iA;
                            oDone <= 1'b1;
                        end else if (dec_mtlo) begin
                            oLO   <= iA;
                            oDone <= 1'b1;
                        end else if (dec_mul || dec_div) begin
                            // Multiply adds |A| while shifting |B| out; divide shifts |A| in.
                            work_hi  <= '0;
                            work_lo  <= dec_div ? a_mag : b_mag;
                            opnd     <= dec_div ? b_mag : a_mag;
                            neg_q    <= a_neg ^ b_neg;
                            neg_r    <= a_neg;
                            div_zero <= dec_div && (iB == '0);
                            mode     <= dec_mode;
                            cnt      <= '0;
                            oBusy    <= 1'b1;
                            state    <= dec_div ? S_DIV : S_MUL;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    work_hi <= step_hi;
                    work_lo <= step_lo;
                    if (cnt == LAST_STEP) begin
                        cnt   <= '0;
                        state <= S_FINISH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_FINISH: begin
                    if (mode == M_DIV) begin
                        if (div_zero) begin
                            oDivByZero <= 1'b1;
                        end else begin
                            oHI <= rem;
                            oLO <= quo;
                        end
                    end else begin
                        {oHI, oLO} <= acc_next;
                    end
                    oDone <= 1'b1;
                    oBusy <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench: driver pushes model results, a negedge monitor pops and compares on oDone.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         iCLK = 1'b0;
    logic         iRST, iStart, iFlush;
    logic [4:0]   iOp;
    logic [W-1:0] iA, iB;
    logic         oBusy, oDone, oDivByZero;
    logic [W-1:0] oHI, oLO;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } exp_t;

    exp_t         sb_q[$];
    exp_t         mon_e;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    muldiv_sequencer #(.DATA_WIDTH(W), .OP_WIDTH(5)) dut (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .iStart     (iStart),
        .iOp        (iOp),
        .iA         (iA),
        .iB         (iB),
        .iFlush     (iFlush),
        .oBusy      (oBusy),
        .oDone      (oDone),
        .oDivByZero (oDivByZero),
        .oHI        (oHI),
        .oLO        (oLO)
    );

    always #5 iCLK = ~iCLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: whole-word arithmetic on 64-bit integers, no iteration.
    function automatic bit model_op(input logic [4:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b, output exp_t e);
        longint      sa, sb;
        logic [63:0] acc, ua, ub;
        logic        dbz;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        acc = {m_hi, m_lo};
        dbz = 1'b0;
        e   = '0;
        case (op)
            OPMULT:  acc = 64'(sa * sb);
            OPMULTU: acc = ua * ub;
            OPMADD:  acc = acc + 64'(sa * sb);
            OPMADDU: acc = acc + ua * ub;
            OPMSUB:  acc = acc - 64'(sa * sb);
            OPMSUBU: acc = acc - ua * ub;
            OPDIV:   if (b == 0) dbz = 1'b1; else acc = {32'(sa % sb), 32'(sa / sb)};
            OPDIVU:  if (b == 0) dbz = 1'b1; else acc = {a % b, a / b};
            OPMTHI:  acc[63:32] = a;
            OPMTLO:  acc[31:0] = a;
            default: return 1'b0;
        endcase
        m_hi = acc[63:32];
        m_lo = acc[31:0];
        e    = {acc[63:32], acc[31:0], dbz};
        return 1'b1;
    endfunction

    always @(negedge iCLK) begin
        if (!iRST) begin
            if (oDivByZero && !oDone) check("dbz_without_done", 64'(oDivByZero), 64'd0);
            if (oDone) begin
                if (sb_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done: got oDone=1, expected no pending operation");
                end else begin
                    mon_e = sb_q.pop_front();
                    check("sb_hi",  64'(oHI), 64'(mon_e.hi));
                    check("sb_lo",  64'(oLO), 64'(mon_e.lo));
                    check("sb_dbz", 64'(oDivByZero), 64'(mon_e.dbz));
                end
            end
        end
    end

    task automatic wait_done(output int cycles, output int busy_cycles);
        cycles      = 0;
        busy_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge iCLK);
            cycles++;
            if (oBusy) busy_cycles++;
            if (oDone) return;
        end
        vectors++;
        miscompares++;
        $display("FAIL done_timeout: got no oDone in %0d cycles, expected oDone", cycles);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the oDone cycle.
    task automatic run_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int cycles, output int busy_cycles);
        exp_t e;
        bit   has_done;
        has_done = model_op(op, a, b, e);
        if (has_done) sb_q.push_back(e);
        iOp    = op;
        iA     = a;
        iB     = b;
        iStart = 1'b1;
        @(posedge iCLK);
        #1;
        iStart = 1'b0;
        iA     = $urandom;
        iB     = $urandom;
        iOp    = 5'($urandom);
        cycles      = 0;
        busy_cycles = 0;
        if (has_done) wait_done(cycles, busy_cycles);
        else repeat (3) @(negedge iCLK);
    endtask

    function automatic logic [W-1:0] rand_val();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return W'($urandom_range(0, 15));
            default: return W'($urandom);
        endcase
    endfunction

    logic [4:0] ops [11] = '{OPMULT, OPMULTU, OPMADD, OPMADDU, OPMSUB, OPMSUBU,
                             OPDIV, OPDIVU, OPMTHI, OPMTLO, OPADD};

    initial begin
        int cyc, bcy;
        iRST = 1'b1; iStart = 1'b0; iFlush = 1'b0; iOp = '0; iA = '0; iB = '0;
        repeat (2) @(negedge iCLK);
        check("reset_hi",   64'(oHI), 64'd0);
        check("reset_lo",   64'(oLO), 64'd0);
        check("reset_busy", 64'(oBusy), 64'd0);
        check("reset_done", 64'(oDone), 64'd0);
        check("reset_dbz",  64'(oDivByZero), 64'd0);
        iRST = 1'b0;
        @(negedge iCLK);

        run_op(OPMULT, 32'hFFFF_FFFE, 32'd3, cyc, bcy);
        check("mult_latency", 64'(cyc), 64'd34);
        check("mult_busy_cycles", 64'(bcy), 64'd33);
        check("mult_result", {oHI, oLO}, 64'hFFFF_FFFF_FFFF_FFFA);

        run_op(OPMULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, bcy);
        check("multu_result", {oHI, oLO}, 64'hFFFF_FFFE_0000_0001);
        run_op(OPMADD, 32'd2, 32'd3, cyc, bcy);
        check("madd_b2b_latency", 64'(cyc), 64'd34);
        check("madd_result", {oHI, oLO}, 64'hFFFF_FFFE_0000_0007);

        run_op(OPDIV, 32'hFFFF_FFF9, 32'd2, cyc, bcy);
        check("div_neg_result", {oHI, oLO}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(OPDIVU, 32'd7, 32'd2, cyc, bcy);
        check("divu_result", {oHI, oLO}, 64'h0000_0001_0000_0003);
        run_op(OPDIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc, bcy);
        check("div_wrap_result", {oHI, oLO}, 64'h0000_0000_8000_0000);
        run_op(OPDIV, 32'd5, 32'd0, cyc, bcy);
        check("div0_flag", 64'(oDivByZero), 64'd1);
        check("div0_keep", {oHI, oLO}, 64'h0000_0000_8000_0000);

        run_op(OPMTHI, 32'h1234_5678, 32'd0, cyc, bcy);
        check("mthi_latency", 64'(cyc), 64'd1);
        check("mthi_busy_cycles", 64'(bcy), 64'd0);
        check("mthi_hi", 64'(oHI), 64'h1234_5678);
        @(negedge iCLK);
        check("mthi_done_single", 64'(oDone), 64'd0);

        run_op(OPADD, 32'hDEAD_BEEF, 32'd1, cyc, bcy);
        check("illegal_op_keep", {oHI, oLO}, {m_hi, m_lo});
        check("illegal_op_busy", 64'(oBusy), 64'd0);

        // Flush mid-multiply, then flush racing a start in IDLE.
        iOp = OPMULT; iA = $urandom; iB = $urandom; iStart = 1'b1;
        @(posedge iCLK);
        #1 iStart = 1'b0;
        repeat (9) @(negedge iCLK);
        iFlush = 1'b1;
        @(negedge iCLK);
        iFlush = 1'b0;
        check("flush_busy", 64'(oBusy), 64'd0);
        iFlush = 1'b1; iStart = 1'b1; iOp = OPMTLO; iA = 32'hCAFE_F00D;
        @(negedge iCLK);
        iFlush = 1'b0; iStart = 1'b0;
        repeat (40) @(negedge iCLK);
        check("flush_keep", {oHI, oLO}, {m_hi, m_lo});

        // Asynchronous reset mid-multiply.
        iOp = OPMULTU; iA = $urandom; iB = $urandom; iStart = 1'b1;
        @(posedge iCLK);
        #1 iStart = 1'b0;
        repeat (9) @(negedge iCLK);
        #2 iRST = 1'b1;
        #1;
        check("async_rst_outputs", {oHI, oLO}, 64'd0);
        check("async_rst_flags", {61'd0, oBusy, oDone, oDivByZero}, 64'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge iCLK);
        iRST = 1'b0;
        @(negedge iCLK);

        for (int i = 0; i < 60; i++) begin
            run_op(ops[$urandom_range(0, 10)], rand_val(), rand_val(), cyc, bcy);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge iCLK);
        end

        repeat (5) @(negedge iCLK);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        check("final_state", {oHI, oLO}, {m_hi, m_lo});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
